// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor layout, descriptor-queue sizing and the CSR status word.
package dma_pkg;

    localparam int DMA_DESCRIPTOR_FIFO_DEPTH         = 16;
    localparam int DMA_DESCRIPTOR_FIFO_DEPTH_ENCODED = $clog2(DMA_DESCRIPTOR_FIFO_DEPTH);
    localparam int DMA_SEQ_W                         = 16;

    typedef struct packed {
        logic       go;
        logic       early_done_enable;
        logic       transfer_complete_irq_mask;
        logic       early_termination_irq_mask;
        logic [7:0] error_irq_mask;
        logic       end_on_eop;
        logic       park_writes;
        logic       park_reads;
        logic       generate_eop;
        logic       generate_sop;
        logic [7:0] transmit_channel;
        logic [6:0] reserved;
    } t_dma_descriptor_control;

    typedef struct packed {
        logic [63:0]             src_addr;
        logic [63:0]             dest_addr;
        logic [63:0]             length;
        t_dma_descriptor_control descriptor_control;
    } t_dma_descriptor;

    // Fields read back through the status and fill-level CSRs.
    typedef struct packed {
        logic                                       busy;
        logic                                       descriptor_fifo_empty;
        logic                                       descriptor_fifo_full;
        logic                                       response_fifo_empty;
        logic                                       response_fifo_full;
        logic                                       stopped;
        logic                                       resetting;
        logic                                       stopped_on_error;
        logic                                       stopped_on_early_termination;
        logic                                       irq;
        logic                                       overflow;
        logic [DMA_DESCRIPTOR_FIFO_DEPTH_ENCODED:0] fill_level;
        logic [DMA_SEQ_W-1:0]                       seq_num;
    } t_dma_csr_status;

endpackage

// File: rtl/dma_descriptor_fifo.sv
// First-word-fall-through descriptor queue between the CSR manager and the dispatcher,
// with flush, sticky overflow and an accepted-descriptor sequence counter.
module dma_descriptor_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH,
    parameter int SEQ_W = DMA_SEQ_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_valid,
    input  logic [$bits(t_dma_descriptor)-1:0] push_desc,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [$bits(t_dma_descriptor)-1:0] pop_desc,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic [SEQ_W-1:0]             seq_num,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_WRAP = {1'b1, {(PW-1){1'b0}}};
    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    t_dma_descriptor   mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_nxt_s;
    logic [PW-1:0]     rd_ptr_nxt_s;
    logic [PW-1:0]     fill_level_r;
    logic [SEQ_W-1:0]  seq_num_r;
    logic              overflow_r;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // Status is decoded from registered pointers only, so there is no path from push/pop inputs.
    assign full_s  = ((wr_ptr_r ^ rd_ptr_r) == PTR_WRAP);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // A flush cycle swallows any push or pop; a full FIFO still accepts a push paired with a pop.
    assign pop_s  = !flush && !empty_s && pop_ready;
    assign push_s = !flush && push_valid && (!full_s || pop_s);
    assign drop_s = !flush && push_valid && full_s && !pop_s;

    // Next-pointer selection.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Pointer, fill-level, sequence-counter and overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fill_level_r <= '0;
            seq_num_r    <= '0;
            overflow_r   <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            fill_level_r <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            if (push_s) begin
                seq_num_r <= seq_num_r + SEQ_ONE;
            end else begin
                seq_num_r <= seq_num_r;
            end
            // A dropped push in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Descriptor storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= t_dma_descriptor'(push_desc);
            end else begin
                mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
            end
        end
    end

    assign pop_valid  = !empty_s;
    assign pop_desc   = mem_r[rd_ptr_r[AW-1:0]];
    assign full       = full_s;
    assign empty      = empty_s;
    assign fill_level = fill_level_r;
    assign seq_num    = seq_num_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_dma_descriptor_fifo.sv
// Directed table-driven bench for dma_descriptor_fifo at DEPTH=4, plus wrap and async-reset sequences.
module tb_dma_descriptor_fifo;
    import dma_pkg::*;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 16;
    localparam int DW    = $bits(t_dma_descriptor);

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   push_valid;
    logic [DW-1:0]          push_desc;
    logic                   pop_valid;
    logic                   pop_ready;
    logic [DW-1:0]          pop_desc;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] fill_level;
    logic [SEQ_W-1:0]       seq_num;
    logic                   overflow;
    logic                   clear_overflow;

    int total_checks;
    int passed_checks;

    dma_descriptor_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_desc      (push_desc),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_desc       (pop_desc),
        .full           (full),
        .empty          (empty),
        .fill_level     (fill_level),
        .seq_num        (seq_num),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic push;
        int   dn;
        logic pop;
        logic fl;
        logic clr;
        logic exp_pv;
        int   exp_dn;
        logic exp_full;
        logic exp_empty;
        int   exp_fill;
        int   exp_seq;
        logic exp_ovf;
    } vec_t;

    vec_t vecs [28];

    function automatic logic [DW-1:0] mk(input int n);
        t_dma_descriptor d;
        d = '0;
        d.src_addr  = 64'h1000 * 64'(n);
        d.dest_addr = 64'h2000 * 64'(n);
        d.length    = 64'h40 * 64'(n);
        d.descriptor_control.go = 1'b1;
        d.descriptor_control.transmit_channel = 8'(n);
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int   errs;
        int   max_fill;
        int   n_wrap;
        total_checks  = 0;
        passed_checks = 0;

        //        push dn  pop  fl   clr   pv  edn  full empty fill seq ovf
        vecs[0]  = '{1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 1, 1,  1'b0};
        vecs[1]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 1,  1'b0};
        vecs[2]  = '{1'b1, 2,  1'b0, 1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 1, 2,  1'b0};
        vecs[3]  = '{1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 2, 3,  1'b0};
        vecs[4]  = '{1'b1, 4,  1'b0, 1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 3, 4,  1'b0};
        vecs[5]  = '{1'b1, 5,  1'b0, 1'b0, 1'b0, 1'b1, 2,  1'b1, 1'b0, 4, 5,  1'b0};
        vecs[6]  = '{1'b1, 6,  1'b0, 1'b0, 1'b0, 1'b1, 2,  1'b1, 1'b0, 4, 5,  1'b1};
        vecs[7]  = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b1, 3,  1'b0, 1'b0, 3, 5,  1'b0};
        vecs[8]  = '{1'b1, 7,  1'b0, 1'b0, 1'b0, 1'b1, 3,  1'b1, 1'b0, 4, 6,  1'b0};
        vecs[9]  = '{1'b1, 8,  1'b1, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0, 4, 7,  1'b0};
        vecs[10] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 5,  1'b0, 1'b0, 3, 7,  1'b0};
        vecs[11] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 7,  1'b0, 1'b0, 2, 7,  1'b0};
        vecs[12] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b1, 8,  1'b0, 1'b0, 1, 7,  1'b0};
        vecs[13] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 7,  1'b0};
        vecs[14] = '{1'b1, 9,  1'b0, 1'b0, 1'b0, 1'b1, 9,  1'b0, 1'b0, 1, 8,  1'b0};
        vecs[15] = '{1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1, 9,  1'b0, 1'b0, 2, 9,  1'b0};
        vecs[16] = '{1'b1, 11, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 9,  1'b0};
        vecs[17] = '{1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0, 1, 10, 1'b0};
        vecs[18] = '{1'b1, 13, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0, 2, 11, 1'b0};
        vecs[19] = '{1'b1, 14, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0, 3, 12, 1'b0};
        vecs[20] = '{1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b0, 4, 13, 1'b0};
        vecs[21] = '{1'b1, 16, 1'b0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b0, 4, 13, 1'b1};
        vecs[22] = '{1'b1, 17, 1'b0, 1'b0, 1'b1, 1'b1, 12, 1'b1, 1'b0, 4, 13, 1'b1};
        vecs[23] = '{1'b0, 0,  1'b0, 1'b0, 1'b1, 1'b1, 12, 1'b1, 1'b0, 4, 13, 1'b0};
        vecs[24] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 13, 1'b0};
        vecs[25] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 13, 1'b0};
        vecs[26] = '{1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b1, 18, 1'b0, 1'b0, 1, 14, 1'b0};
        vecs[27] = '{1'b1, 19, 1'b1, 1'b0, 1'b0, 1'b1, 19, 1'b0, 1'b0, 1, 15, 1'b0};

        reset          = 1'b1;
        flush          = 1'b0;
        push_valid     = 1'b0;
        push_desc      = '0;
        pop_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("reset_pop_valid", 256'(pop_valid), 256'(1'b0));
        chk("reset_empty", 256'(empty), 256'(1'b1));
        chk("reset_full", 256'(full), 256'(1'b0));
        chk("reset_fill", 256'(fill_level), 256'(0));
        chk("reset_seq", 256'(seq_num), 256'(0));
        chk("reset_ovf", 256'(overflow), 256'(1'b0));
        chk("reset_desc", 256'(pop_desc), 256'(0));

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            push_valid     = vecs[i].push;
            push_desc      = vecs[i].push ? mk(vecs[i].dn) : '0;
            pop_ready      = vecs[i].pop;
            flush          = vecs[i].fl;
            clear_overflow = vecs[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pop_valid", i), 256'(pop_valid), 256'(vecs[i].exp_pv));
            chk($sformatf("v%0d_full", i), 256'(full), 256'(vecs[i].exp_full));
            chk($sformatf("v%0d_empty", i), 256'(empty), 256'(vecs[i].exp_empty));
            chk($sformatf("v%0d_fill", i), 256'(fill_level), 256'(vecs[i].exp_fill));
            chk($sformatf("v%0d_seq", i), 256'(seq_num), 256'(vecs[i].exp_seq));
            chk($sformatf("v%0d_ovf", i), 256'(overflow), 256'(vecs[i].exp_ovf));
            if (vecs[i].exp_pv) begin
                chk($sformatf("v%0d_desc", i), 256'(pop_desc), 256'(mk(vecs[i].exp_dn)));
            end
        end

        // Streaming push+pop pairs from seq_num=15 until the counter wraps to 1.
        n_wrap   = 65536 - 15 + 1;
        errs     = 0;
        max_fill = 0;
        for (int i = 0; i < n_wrap; i++) begin
            @(negedge clk);
            push_valid     = 1'b1;
            push_desc      = mk(100 + i);
            pop_ready      = 1'b1;
            flush          = 1'b0;
            clear_overflow = 1'b0;
            @(posedge clk);
            #1;
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (pop_desc !== mk(100 + i) || !pop_valid) errs++;
        end
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        chk("wrap_head_errors", 256'(errs), 256'(0));
        chk("wrap_max_fill", 256'(max_fill), 256'(1));
        chk("wrap_seq", 256'(seq_num), 256'(1));
        chk("wrap_fill", 256'(fill_level), 256'(1));
        chk("wrap_pop_valid", 256'(pop_valid), 256'(1'b1));

        // Asynchronous reset while an entry is presented.
        #2;
        reset = 1'b1;
        #1;
        chk("areset_pop_valid", 256'(pop_valid), 256'(1'b0));
        chk("areset_empty", 256'(empty), 256'(1'b1));
        chk("areset_fill", 256'(fill_level), 256'(0));
        chk("areset_seq", 256'(seq_num), 256'(0));
        chk("areset_desc", 256'(pop_desc), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_empty", 256'(empty), 256'(1'b1));

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
